// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Feeds the execute-stage ALU its A/B operands and opcode with no added latency.
package control_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;
endpackage

module id_ex_operand_stage
    import control_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  alu_op_e           id_alu_op,
    input  logic              id_a_sel_pc,
    input  logic              id_b_sel_imm,
    input  logic              id_reg_we,
    input  logic              id_mem_rd,
    input  logic              ex_hold,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_reg_we,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_reg_we,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output alu_op_e           alu_op,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_we,
    output logic              ex_mem_rd,
    output logic [XLEN-1:0]   ex_store_data,
    output logic              id_stall
);
    localparam logic [REG_AW-1:0] X0 = '0;

    logic              ex_valid_q;
    logic              reg_we_q;
    logic              mem_rd_q;
    logic              a_sel_pc_q;
    logic              b_sel_imm_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   imm_q;
    logic [REG_AW-1:0] rd_q;
    alu_op_e           alu_op_q;
    logic              load_use;

    logic [REG_AW-1:0] id_rs_addr [2];
    logic [XLEN-1:0]   id_rs_data [2];
    logic [XLEN-1:0]   fwd_data   [2];

    assign id_rs_addr[0] = id_rs1_addr;
    assign id_rs_addr[1] = id_rs2_addr;
    assign id_rs_data[0] = id_rs1_data;
    assign id_rs_data[1] = id_rs2_data;

    assign load_use = ex_valid_q && mem_rd_q && (rd_q != X0) && id_valid &&
                      ((rd_q == id_rs1_addr) || (rd_q == id_rs2_addr));
    assign id_stall = load_use || ex_hold;

    // Write flags are stored already qualified by valid so ex_reg_we/ex_mem_rd need no gating.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            reg_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            a_sel_pc_q  <= 1'b0;
            b_sel_imm_q <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            alu_op_q    <= ALU_ADD;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
            reg_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
        end else if (!ex_hold) begin
            if (load_use) begin
                ex_valid_q <= 1'b0;
                reg_we_q   <= 1'b0;
                mem_rd_q   <= 1'b0;
            end else begin
                ex_valid_q  <= id_valid;
                reg_we_q    <= id_valid && id_reg_we;
                mem_rd_q    <= id_valid && id_mem_rd;
                a_sel_pc_q  <= id_a_sel_pc;
                b_sel_imm_q <= id_b_sel_imm;
                pc_q        <= id_pc;
                imm_q       <= id_imm;
                rd_q        <= id_rd_addr;
                alu_op_q    <= id_alu_op;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic [REG_AW-1:0] addr_q;
            logic [XLEN-1:0]   data_q;
            logic              mem_hit;
            logic              wb_hit;

            assign mem_hit = mem_reg_we && (mem_rd_addr != X0) && (mem_rd_addr == addr_q);
            assign wb_hit  = wb_reg_we && (wb_rd_addr != X0) && (wb_rd_addr == addr_q);

            // While frozen, absorb WB writes so the value survives WB retiring.
            always_ff @(posedge clk) begin
                if (rst) begin
                    addr_q <= '0;
                    data_q <= '0;
                end else if (!flush) begin
                    if (ex_hold) begin
                        if (wb_hit) begin
                            data_q <= wb_data;
                        end
                    end else if (!load_use) begin
                        addr_q <= id_rs_addr[gi];
                        data_q <= id_rs_data[gi];
                    end
                end
            end

            assign fwd_data[gi] = mem_hit ? mem_fwd_data :
                                  wb_hit  ? wb_data      : data_q;
        end
    endgenerate

    assign alu_a         = a_sel_pc_q  ? pc_q  : fwd_data[0];
    assign alu_b         = b_sel_imm_q ? imm_q : fwd_data[1];
    assign ex_store_data = fwd_data[1];
    assign alu_op        = alu_op_q;
    assign ex_valid      = ex_valid_q;
    assign ex_rd_addr    = rd_q;
    assign ex_reg_we     = reg_we_q;
    assign ex_mem_rd     = mem_rd_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios with literal expectations, then random
// traffic compared every cycle against a slot-level model of the EX register.
module tb_id_ex_operand_stage;
    import control_pkg::*;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rd_addr;
    alu_op_e     id_alu_op;
    logic        id_a_sel_pc;
    logic        id_b_sel_imm;
    logic        id_reg_we;
    logic        id_mem_rd;
    logic        ex_hold;
    logic        flush;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_we;
    logic [31:0] mem_fwd_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_we;
    logic [31:0] wb_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_op_e     alu_op;
    logic        ex_valid;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_we;
    logic        ex_mem_rd;
    logic [31:0] ex_store_data;
    logic        id_stall;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    id_ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rd_addr(id_rd_addr), .id_alu_op(id_alu_op),
        .id_a_sel_pc(id_a_sel_pc), .id_b_sel_imm(id_b_sel_imm),
        .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd), .ex_hold(ex_hold), .flush(flush),
        .mem_rd_addr(mem_rd_addr), .mem_reg_we(mem_reg_we), .mem_fwd_data(mem_fwd_data),
        .wb_rd_addr(wb_rd_addr), .wb_reg_we(wb_reg_we), .wb_data(wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid),
        .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
        .ex_store_data(ex_store_data), .id_stall(id_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the EX slot holds; 'known' is false after a bubble or flush (data don't-care).
    typedef struct {
        bit          valid, we, mrd, asel, bsel, known;
        logic [31:0] pc, imm, d1, d2;
        logic [4:0]  a1, a2, rd;
        alu_op_e     op;
    } ex_t;
    ex_t m;

    function automatic ex_t reset_slot();
        ex_t s;
        s.valid = 0; s.we = 0; s.mrd = 0; s.asel = 0; s.bsel = 0; s.known = 1;
        s.pc = 0; s.imm = 0; s.d1 = 0; s.d2 = 0; s.a1 = 0; s.a2 = 0; s.rd = 0;
        s.op = ALU_ADD;
        return s;
    endfunction

    function automatic bit wb_hits(logic [4:0] a);
        return wb_reg_we && wb_rd_addr != 0 && wb_rd_addr == a;
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] a, logic [31:0] stored);
        if (mem_reg_we && mem_rd_addr != 0 && mem_rd_addr == a) return mem_fwd_data;
        if (wb_hits(a)) return wb_data;
        return stored;
    endfunction

    function automatic bit model_stall();
        return ex_hold || (m.valid && m.mrd && m.rd != 0 && id_valid &&
                           (m.rd == id_rs1_addr || m.rd == id_rs2_addr));
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
        chk("ex_reg_we", {31'd0, ex_reg_we}, {31'd0, m.valid & m.we});
        chk("ex_mem_rd", {31'd0, ex_mem_rd}, {31'd0, m.valid & m.mrd});
        chk("id_stall", {31'd0, id_stall}, {31'd0, model_stall()});
        if (m.known) begin
            chk("alu_a", alu_a, m.asel ? m.pc : fwd(m.a1, m.d1));
            chk("alu_b", alu_b, m.bsel ? m.imm : fwd(m.a2, m.d2));
            chk("store_data", ex_store_data, fwd(m.a2, m.d2));
            chk("alu_op", {28'd0, alu_op}, {28'd0, m.op});
            chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, m.rd});
        end
    endtask

    task automatic update_model();
        bit stall;
        stall = model_stall();
        if (rst) begin
            m = reset_slot();
        end else if (flush) begin
            m.valid = 0; m.we = 0; m.mrd = 0; m.known = 0;
        end else if (ex_hold) begin
            if (wb_hits(m.a1)) m.d1 = wb_data;
            if (wb_hits(m.a2)) m.d2 = wb_data;
        end else if (stall) begin
            m.valid = 0; m.we = 0; m.mrd = 0; m.known = 0;
        end else begin
            m.valid = id_valid; m.we = id_valid & id_reg_we; m.mrd = id_valid & id_mem_rd;
            m.asel = id_a_sel_pc; m.bsel = id_b_sel_imm; m.known = 1;
            m.pc = id_pc; m.imm = id_imm; m.d1 = id_rs1_data; m.d2 = id_rs2_data;
            m.a1 = id_rs1_addr; m.a2 = id_rs2_addr; m.rd = id_rd_addr; m.op = id_alu_op;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compare_model();
        $display("cyc %0d: v=%b a=%h b=%h op=%0d rd=%0d we=%b ld=%b stall=%b", cyc, ex_valid,
                 alu_a, alu_b, alu_op, ex_rd_addr, ex_reg_we, ex_mem_rd, id_stall);
    endtask

    task automatic advance();
        @(posedge clk);
        update_model();
        cyc++;
        #1;
    endtask

    task automatic idle_id();
        id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0;
        id_rs2_data = 0; id_imm = 0; id_rd_addr = 0; id_alu_op = ALU_ADD;
        id_a_sel_pc = 0; id_b_sel_imm = 0; id_reg_we = 0; id_mem_rd = 0;
    endtask

    task automatic idle_fwd();
        mem_rd_addr = 0; mem_reg_we = 0; mem_fwd_data = 0;
        wb_rd_addr = 0; wb_reg_we = 0; wb_data = 0;
    endtask

    task automatic set_id(logic [4:0] r1, logic [31:0] d1, logic [4:0] r2, logic [31:0] d2,
                          logic [4:0] rd, bit we, bit ld);
        id_valid = 1; id_pc = 32'h100; id_rs1_addr = r1; id_rs1_data = d1;
        id_rs2_addr = r2; id_rs2_data = d2; id_imm = 32'h4; id_rd_addr = rd;
        id_alu_op = ALU_ADD; id_a_sel_pc = 0; id_b_sel_imm = 0; id_reg_we = we; id_mem_rd = ld;
    endtask

    task automatic set_fwd_mem(logic [4:0] a, logic [31:0] d);
        mem_rd_addr = a; mem_reg_we = 1; mem_fwd_data = d;
    endtask

    task automatic set_fwd_wb(logic [4:0] a, logic [31:0] d);
        wb_rd_addr = a; wb_reg_we = 1; wb_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        m = reset_slot();
        rst = 1; ex_hold = 0; flush = 0;
        idle_id(); idle_fwd();
        advance(); advance();

        // Reset state
        rst = 0;
        sample();
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst id_stall", {31'd0, id_stall}, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
        advance();

        // Plain capture, no forwarding
        set_id(5'd1, 32'h5, 5'd2, 32'h7, 5'd3, 1, 0);
        sample(); advance();
        idle_id();
        sample();
        chk("t1 ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("t1 alu_a", alu_a, 32'h5);
        chk("t1 alu_b", alu_b, 32'h7);
        advance();

        // MEM wins over WB
        set_id(5'd1, 32'h1, 5'd2, 32'h2, 5'd5, 1, 0);
        sample(); advance();
        idle_id(); set_fwd_mem(5'd1, 32'h10); set_fwd_wb(5'd1, 32'h20);
        sample();
        chk("t2 alu_a mem prio", alu_a, 32'h10);
        advance(); idle_fwd();

        // x0 never forwarded
        set_id(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 0, 0);
        sample(); advance();
        idle_id(); set_fwd_mem(5'd0, 32'hFF); set_fwd_wb(5'd0, 32'hEE);
        sample();
        chk("t3 alu_a x0", alu_a, 32'h0);
        advance(); idle_fwd();

        // Load-use: one stall, one bubble, then capture with MEM forward
        set_id(5'd1, 32'h40, 5'd0, 32'h0, 5'd3, 1, 1);
        sample(); advance();
        set_id(5'd4, 32'h9, 5'd3, 32'hDEAD, 5'd6, 1, 0);
        sample();
        chk("t4 stall", {31'd0, id_stall}, 32'd1);
        advance();
        sample();
        chk("t4 bubble valid", {31'd0, ex_valid}, 32'd0);
        chk("t4 stall released", {31'd0, id_stall}, 32'd0);
        advance();
        idle_id(); set_fwd_mem(5'd3, 32'h33);
        sample();
        chk("t4 captured valid", {31'd0, ex_valid}, 32'd1);
        chk("t4 alu_b mem fwd", alu_b, 32'h33);
        advance(); idle_fwd();

        // Hold for 3 cycles with a WB write to rs2 in the middle
        set_id(5'd1, 32'h1, 5'd2, 32'h7, 5'd4, 1, 0);
        sample(); advance();
        idle_id(); ex_hold = 1;
        sample();
        chk("t5 hold stall", {31'd0, id_stall}, 32'd1);
        advance();
        set_fwd_wb(5'd2, 32'hAB);
        sample(); advance();
        idle_fwd();
        sample(); advance();
        ex_hold = 0;
        sample();
        chk("t5 alu_b after hold", alu_b, 32'hAB);
        chk("t5 valid after hold", {31'd0, ex_valid}, 32'd1);
        advance();

        // Flush beats hold
        set_id(5'd1, 32'h1, 5'd2, 32'h2, 5'd7, 1, 0);
        sample(); advance();
        idle_id(); flush = 1; ex_hold = 1;
        sample(); advance();
        flush = 0; ex_hold = 0;
        sample();
        chk("t6 flush valid", {31'd0, ex_valid}, 32'd0);
        chk("t6 flush reg_we", {31'd0, ex_reg_we}, 32'd0);
        advance();

        // Reset in the middle of a load-use stall
        set_id(5'd1, 32'h1, 5'd0, 32'h0, 5'd3, 1, 1);
        sample(); advance();
        set_id(5'd3, 32'h5, 5'd0, 32'h0, 5'd8, 1, 0);
        sample();
        chk("t6 pre-rst stall", {31'd0, id_stall}, 32'd1);
        rst = 1;
        advance();
        sample();
        chk("t6 rst valid", {31'd0, ex_valid}, 32'd0);
        chk("t6 rst mem_rd", {31'd0, ex_mem_rd}, 32'd0);
        chk("t6 rst reg_we", {31'd0, ex_reg_we}, 32'd0);
        chk("t6 rst stall", {31'd0, id_stall}, 32'd0);
        chk("t6 rst alu_a", alu_a, 32'd0);
        chk("t6 rst alu_b", alu_b, 32'd0);
        chk("t6 rst rd", {27'd0, ex_rd_addr}, 32'd0);
        rst = 0;
        advance();

        // Random traffic with a small register window to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            rst          = ($urandom_range(0, 99) < 1);
            flush        = ($urandom_range(0, 99) < 5);
            ex_hold      = ($urandom_range(0, 99) < 15);
            id_valid     = ($urandom_range(0, 99) < 80);
            id_pc        = $urandom;
            id_rs1_addr  = 5'($urandom_range(0, 3));
            id_rs2_addr  = 5'($urandom_range(0, 3));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            id_rd_addr   = 5'($urandom_range(0, 3));
            id_alu_op    = alu_op_e'($urandom_range(0, 10));
            id_a_sel_pc  = ($urandom_range(0, 3) == 0);
            id_b_sel_imm = ($urandom_range(0, 2) == 0);
            id_reg_we    = ($urandom_range(0, 3) != 0);
            id_mem_rd    = ($urandom_range(0, 2) == 0);
            mem_rd_addr  = 5'($urandom_range(0, 3));
            mem_reg_we   = ($urandom_range(0, 1) == 0);
            mem_fwd_data = $urandom;
            wb_rd_addr   = 5'($urandom_range(0, 3));
            wb_reg_we    = ($urandom_range(0, 1) == 0);
            wb_data      = $urandom;
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
